pa_ifu_lockup_ctrl: RTL and testbench

IFU-side responder for the RTU lockup handshake. When RTU signals a lockup (a nested exception inside an exception/NMI handler), this block stalls new instruction fetches, flushes the instruction buffer and drains outstanding fetch-bus transactions. It then acknowledges RTU and holds fetch masked until RTU releases the mask. It sits in the IFU between the RTU lockup interface and the fetch request/instruction-buffer logic.

---
 rtl/pa_ifu_lockup_ctrl_pkg.sv | 16 +
 rtl/pa_ifu_lockup_outstd_cnt.sv | 28 ++
 rtl/pa_ifu_lockup_ctrl.sv | 80 ++++++++
 tb/tb_pa_ifu_lockup_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_ifu_lockup_ctrl_pkg.sv
// Shared IFU lockup definitions: FSM state encodings and outstanding-fetch limits.
// No logic, no latency; referenced by the lockup controller and its counter.
package pa_ifu_lockup_ctrl_pkg;

  localparam int LOCKUP_MAX_OUTSTD = 2;
  localparam int LOCKUP_CNT_W      = 2;

  typedef enum logic [2:0] {
    LOCKUP_IDLE  = 3'b000,
    LOCKUP_FLUSH = 3'b001,
    LOCKUP_DRAIN = 3'b010,
    LOCKUP_ACK   = 3'b011,
    LOCKUP_HOLD  = 3'b100
  } lockup_st_e;

endpackage

// File: rtl/pa_ifu_lockup_outstd_cnt.sv
// Saturating up/down count of fetch-bus transactions in flight; registered, 1-cycle update.
// No backpressure: grant and last-beat are event strobes that are never refused.
module pa_ifu_lockup_outstd_cnt #(
  parameter int MAX_OUTSTD = 2,
  parameter int CNT_W      = 2
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             cnt_inc,
  input  logic             cnt_dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A grant and a last beat in the same cycle cancel out.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      cnt <= '0;
    end else if (cnt_inc && !cnt_dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else if (cnt_dec && !cnt_inc && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/pa_ifu_lockup_ctrl.sv
// IFU responder to RTU lockup: stall fetch, flush ibuf, drain bus, ack, hold until mask drops.
// Ack no earlier than 3 cycles after req; stall is asserted in the same cycle the request is seen.
module pa_ifu_lockup_ctrl
  import pa_ifu_lockup_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTD = LOCKUP_MAX_OUTSTD,
  parameter int CNT_W      = LOCKUP_CNT_W
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             rtu_ifu_lockup_expt_vld,
  input  logic             rtu_ifu_lockup_req,
  input  logic             rtu_ifu_lockup_mask,
  input  logic             bus_lockup_req_grnt,
  input  logic             bus_lockup_rsp_last,
  input  logic             ibuf_lockup_empty,
  output logic             ifu_rtu_lockup_ack,
  output logic             lockup_fetch_stall,
  output logic             lockup_ibuf_flush,
  output logic             lockup_refetch,
  output logic [CNT_W-1:0] lockup_outstd_cnt,
  output logic [2:0]       lockup_cur_st
);

  lockup_st_e cur_st;
  logic       pipe_idle;

  pa_ifu_lockup_outstd_cnt #(
    .MAX_OUTSTD (MAX_OUTSTD),
    .CNT_W      (CNT_W)
  ) u_outstd_cnt (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .cnt_inc        (bus_lockup_req_grnt),
    .cnt_dec        (bus_lockup_rsp_last),
    .cnt            (lockup_outstd_cnt)
  );

  assign pipe_idle = (lockup_outstd_cnt == '0) && ibuf_lockup_empty;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      cur_st <= LOCKUP_IDLE;
    end else begin
      case (cur_st)
        LOCKUP_IDLE:  if (rtu_ifu_lockup_expt_vld || rtu_ifu_lockup_req) cur_st <= LOCKUP_FLUSH;
        LOCKUP_FLUSH: cur_st <= LOCKUP_DRAIN;
        LOCKUP_DRAIN: begin
          if (!rtu_ifu_lockup_req) cur_st <= LOCKUP_IDLE;
          else if (pipe_idle)      cur_st <= LOCKUP_ACK;
        end
        LOCKUP_ACK:   cur_st <= rtu_ifu_lockup_req ? LOCKUP_HOLD : LOCKUP_IDLE;
        // Mask loss (NMI/debug entry) wins over a fresh request.
        LOCKUP_HOLD: begin
          if (!rtu_ifu_lockup_mask)    cur_st <= LOCKUP_IDLE;
          else if (rtu_ifu_lockup_req) cur_st <= LOCKUP_DRAIN;
        end
        default:      cur_st <= LOCKUP_IDLE;
      endcase
    end
  end

  // Ack and refetch are gated by reset so a reset edge never emits either pulse.
  assign ifu_rtu_lockup_ack = cpurst_b && (cur_st == LOCKUP_ACK) && rtu_ifu_lockup_req;
  assign lockup_ibuf_flush  = (cur_st == LOCKUP_FLUSH);
  assign lockup_refetch     = cpurst_b &&
                              ((((cur_st == LOCKUP_DRAIN) || (cur_st == LOCKUP_ACK)) && !rtu_ifu_lockup_req) ||
                               ((cur_st == LOCKUP_HOLD) && !rtu_ifu_lockup_mask));
  assign lockup_cur_st      = cur_st;

  always_comb begin
    lockup_fetch_stall = 1'b1;
    case (cur_st)
      LOCKUP_IDLE: lockup_fetch_stall = rtu_ifu_lockup_expt_vld || rtu_ifu_lockup_req;
      LOCKUP_HOLD: lockup_fetch_stall = rtu_ifu_lockup_mask;
      default:     lockup_fetch_stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pa_ifu_lockup_ctrl.sv
// Bench for pa_ifu_lockup_ctrl: directed scenarios plus random traffic against a
// cycle-level protocol model.
module tb_pa_ifu_lockup_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, expt, req, mask, grnt, last, empty;
  logic       ack, stall, flush, refetch;
  logic [1:0] cnt;
  logic [2:0] st;
  logic [8:0] dut_vec;
  int         checks = 0;
  int         errors = 0;

  // Reference model: protocol phase (0 idle,1 flush,2 drain,3 ack,4 hold) and transaction count.
  int m_ph  = 0;
  int m_cnt = 0;

  pa_ifu_lockup_ctrl dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_n),
    .rtu_ifu_lockup_expt_vld (expt),
    .rtu_ifu_lockup_req      (req),
    .rtu_ifu_lockup_mask     (mask),
    .bus_lockup_req_grnt     (grnt),
    .bus_lockup_rsp_last     (last),
    .ibuf_lockup_empty       (empty),
    .ifu_rtu_lockup_ack      (ack),
    .lockup_fetch_stall      (stall),
    .lockup_ibuf_flush       (flush),
    .lockup_refetch          (refetch),
    .lockup_outstd_cnt       (cnt),
    .lockup_cur_st           (st)
  );

  always #5 clk = ~clk;
  assign dut_vec = {ack, stall, flush, refetch, cnt, st};

  function automatic logic [8:0] mdl_vec();
    logic a, s, f, r;
    a = rst_n && (m_ph == 3) && req;
    s = (m_ph == 0) ? (expt || req) : ((m_ph == 4) ? mask : 1'b1);
    f = (m_ph == 1);
    r = rst_n && ((((m_ph == 2) || (m_ph == 3)) && !req) || ((m_ph == 4) && !mask));
    return {a, s, f, r, 2'(m_cnt), 3'(m_ph)};
  endfunction

  task automatic mdl_step();
    if (!rst_n) begin
      m_ph = 0; m_cnt = 0;
    end else begin
      case (m_ph)
        0: if (expt || req) m_ph = 1;
        1: m_ph = 2;
        2: if (!req) m_ph = 0; else if (m_cnt == 0 && empty) m_ph = 3;
        3: m_ph = req ? 4 : 0;
        4: if (!mask) m_ph = 0; else if (req) m_ph = 2;
        default: m_ph = 0;
      endcase
      m_cnt = m_cnt + int'(grnt) - int'(last);
      if (m_cnt > 2) m_cnt = 2;
      if (m_cnt < 0) m_cnt = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst_n = 0; expt = 0; req = 0; mask = 0; grnt = 0; last = 0; empty = 1;
    adv(); adv();
    #3;
    checks++;
    if (dut_vec !== 9'd0) begin
      errors++; $display("FAIL reset_state dut=%b expected=%b", dut_vec, 9'd0);
    end
    req = 1; #1;
    exp = mdl_vec();
    checks++;
    if (dut_vec !== exp) begin
      errors++; $display("FAIL reset_stall_comb dut=%b expected=%b", dut_vec, exp);
    end
    adv();
    req = 0; rst_n = 1;
  endtask

  task automatic test_empty_pipe();
    logic [8:0] exp;
    for (int c = 0; c <= 22; c++) begin
      expt = (c == 10); req = (c >= 11 && c <= 13); mask = (c >= 11 && c <= 19);
      grnt = 0; last = 0; empty = 1;
      #3;
      exp = mdl_vec();
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL empty_pipe c=%0d dut=%b expected=%b", c, dut_vec, exp);
      end
      checks++;
      if (ack !== (c == 13)) begin
        errors++; $display("FAIL empty_pipe_ack c=%0d dut=%b expected=%b", c, ack, (c == 13));
      end
      if (c == 11) begin
        checks++;
        if (flush !== 1'b1) begin errors++; $display("FAIL empty_pipe_flush dut=%b expected=1", flush); end
      end
      if (c == 14) begin
        checks++;
        if (st !== 3'b100) begin errors++; $display("FAIL empty_pipe_hold dut=%b expected=100", st); end
      end
      if (c == 20) begin
        checks++;
        if (refetch !== 1'b1) begin errors++; $display("FAIL empty_pipe_refetch dut=%b expected=1", refetch); end
      end
      if (c >= 20) begin
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL empty_pipe_stall c=%0d dut=%b expected=0", c, stall); end
      end
      adv();
    end
  endtask

  task automatic test_outstd_drain();
    logic [8:0] exp;
    logic       acked;
    int         n_ack;
    acked = 0; n_ack = 0;
    for (int c = 0; c <= 22; c++) begin
      grnt = (c < 2); last = (c == 9 || c == 12); empty = 1; expt = 0;
      req = (c >= 4) && !acked; mask = (c >= 4 && c < 18);
      #3;
      exp = mdl_vec();
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL outstd_drain c=%0d dut=%b expected=%b", c, dut_vec, exp);
      end
      if (c == 9 || c == 10 || c == 13) begin
        checks++;
        if (cnt !== ((c == 9) ? 2'd2 : (c == 10) ? 2'd1 : 2'd0)) begin
          errors++; $display("FAIL outstd_cnt c=%0d dut=%0d", c, cnt);
        end
      end
      if (ack === 1'b1) n_ack++;
      if (exp[8]) acked = 1;
      adv();
    end
    checks++;
    if (n_ack != 1) begin errors++; $display("FAIL outstd_ack_count dut=%0d expected=1", n_ack); end
  endtask

  task automatic test_simultaneous();
    int g[7]    = '{1, 1, 1, 1, 0, 0, 0};
    int l[7]    = '{0, 1, 0, 0, 1, 1, 1};
    int expc[7] = '{1, 1, 2, 2, 1, 0, 0};
    expt = 0; req = 0; mask = 0; empty = 1;
    for (int i = 0; i < 7; i++) begin
      grnt = g[i][0]; last = l[i][0];
      #3;
      adv();
      checks++;
      if (cnt !== 2'(expc[i])) begin
        errors++; $display("FAIL simult_cnt step=%0d dut=%0d expected=%0d", i, cnt, expc[i]);
      end
    end
    grnt = 0; last = 0;
  endtask

  task automatic test_nmi_relock();
    logic [8:0] exp;
    logic       req_r;
    int         n_ack, n_flush, n_refetch;
    req_r = 0; n_ack = 0; n_flush = 0; n_refetch = 0;
    for (int c = 0; c <= 30; c++) begin
      if (c == 3 || c == 14) req_r = 1;
      expt = (c == 2 || c == 13); req = req_r;
      mask = (c >= 3 && c < 10) || (c >= 14 && c < 22);
      grnt = 0; last = 0; empty = 1;
      #3;
      exp = mdl_vec();
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL nmi_relock c=%0d dut=%b expected=%b", c, dut_vec, exp);
      end
      checks++;
      if (ack !== (c == 5 || c == 16)) begin
        errors++; $display("FAIL nmi_relock_ack c=%0d dut=%b", c, ack);
      end
      n_ack += int'(ack === 1'b1); n_flush += int'(flush === 1'b1); n_refetch += int'(refetch === 1'b1);
      if (exp[8]) req_r = 0;
      adv();
    end
    checks++;
    if (n_ack != 2 || n_flush != 2 || n_refetch != 2) begin
      errors++; $display("FAIL nmi_relock_counts ack=%0d flush=%0d refetch=%0d expected=2/2/2", n_ack, n_flush, n_refetch);
    end
  endtask

  task automatic test_ibuf_not_empty();
    logic [8:0] exp;
    logic       req_r;
    req_r = 0;
    for (int c = 0; c <= 16; c++) begin
      if (c == 2) req_r = 1;
      expt = 0; req = req_r; mask = (c >= 2 && c < 12);
      grnt = 0; last = 0; empty = !(c >= 4 && c <= 7);
      #3;
      exp = mdl_vec();
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL ibuf_wait c=%0d dut=%b expected=%b", c, dut_vec, exp);
      end
      checks++;
      if (ack !== (c == 9)) begin
        errors++; $display("FAIL ibuf_wait_ack c=%0d dut=%b expected=%b", c, ack, (c == 9));
      end
      if (exp[8]) req_r = 0;
      adv();
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    for (int c = 0; c <= 10; c++) begin
      grnt = (c == 0); last = 0; empty = 1; expt = 0;
      req = (c >= 2 && c < 6); mask = req; rst_n = (c != 5);
      #3;
      exp = mdl_vec();
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL reset_mid c=%0d dut=%b expected=%b", c, dut_vec, exp);
      end
      if (c == 5) begin
        checks++;
        if (st !== 3'b010 || cnt !== 2'd1) begin
          errors++; $display("FAIL reset_mid_pre st=%b cnt=%0d expected=010/1", st, cnt);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (ack !== 1'b0 || refetch !== 1'b0) begin
          errors++; $display("FAIL reset_mid_pulse c=%0d ack=%b refetch=%b expected=0/0", c, ack, refetch);
        end
      end
      if (c == 6) begin
        checks++;
        if (st !== 3'b000 || cnt !== 2'd0) begin
          errors++; $display("FAIL reset_mid_post st=%b cnt=%0d expected=000/0", st, cnt);
        end
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      expt  = ($urandom_range(0, 7) == 0);
      req   = ($urandom_range(0, 1) == 0);
      mask  = ($urandom_range(0, 3) != 0);
      grnt  = ($urandom_range(0, 2) == 0);
      last  = ($urandom_range(0, 2) == 0);
      empty = ($urandom_range(0, 3) != 0);
      #3;
      exp = mdl_vec();
      checks++;
      if (dut_vec !== exp) begin
        errors++; $display("FAIL random c=%0d dut=%b expected=%b", c, dut_vec, exp);
      end
      checks++;
      if ((ack === 1'b1 && req !== 1'b1) || (flush === 1'b1 && refetch === 1'b1)) begin
        errors++; $display("FAIL random_invariant c=%0d ack=%b req=%b flush=%b refetch=%b", c, ack, req, flush, refetch);
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_empty_pipe();
    test_outstd_drain();
    test_simultaneous();
    test_nmi_relock();
    test_ibuf_not_empty();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
